// File: rtl/ship_life_pkg.sv
// Shared types and widths for the ship life sequencer.
package ship_life_pkg;

    localparam int DEFAULT_MAX_NUM_LIVES = 10;
    localparam int LIVES_W               = $clog2(DEFAULT_MAX_NUM_LIVES + 1);

    typedef enum logic [2:0] {
        WAIT_START,
        ALIVE,
        EXPLODE,
        RESPAWN,
        INVULN,
        OVER
    } life_state_t;

endpackage

// File: rtl/ship_life_ctrl_frame_timer.sv
// Vsync-driven down-counter: load, auto-reload on terminal count, clear.
// count_nxt is exposed so the owner can register outputs that track the
// count on the same edge it changes.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         enable,
    input  logic         tick,
    input  logic [W-1:0] reload_val,
    output logic [W-1:0] count_nxt,
    output logic         tc
);

    logic [W-1:0] count;

    // Terminal count: the tick that arrives while the counter sits at zero.
    assign tc = enable && tick && (count == '0);

    // Next-count selection; clear wins over load, load wins over counting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else if (load || tc)
            count_nxt = reload_val;
        else if (enable && tick)
            count_nxt = count - 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/ship_life_ctrl.sv
// Per-life sequencer: die -> explode -> respawn -> invulnerable, timed in frames.
// Every output is a flop loaded from the next-state decode, so each output
// always agrees with the state register it sits beside.
module ship_life_ctrl
    import ship_life_pkg::*;
#(
    parameter  int NUM_LIVES       = 3,
    parameter  int MAX_NUM_LIVES   = DEFAULT_MAX_NUM_LIVES,
    parameter  int EXPLODE_STEPS   = 4,
    parameter  int FRAMES_PER_STEP = 6,
    parameter  int INVULN_FRAMES   = 90,
    parameter  int BLINK_LOG2      = 3,
    localparam int LW              = $clog2(MAX_NUM_LIVES + 1),
    localparam int EFW             = ($clog2(EXPLODE_STEPS) > 0) ? $clog2(EXPLODE_STEPS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           vsync_pulse,
    input  logic           start_done,
    input  logic           collision,
    input  logic           bonus,
    output logic [LW-1:0]  lives,
    output logic           game_over,
    output logic           ship_draw,
    output logic           invulnerable,
    output logic           explode_active,
    output logic [EFW-1:0] explode_frame,
    output logic           ship_respawn
);

    // One timer serves both explosion steps and invulnerability; it must
    // hold the larger of the two periods.
    localparam int TIMER_MAX = (FRAMES_PER_STEP > INVULN_FRAMES) ? FRAMES_PER_STEP : INVULN_FRAMES;
    localparam int TW        = ($clog2(TIMER_MAX) > 0) ? $clog2(TIMER_MAX) : 1;

    life_state_t    state, state_nxt;
    logic [LW-1:0]  lives_nxt;
    logic [EFW-1:0] explode_frame_nxt;
    logic           ship_draw_nxt;
    logic [TW-1:0]  timer_nxt, timer_reload, invuln_elapsed;
    logic           timer_tc, timer_load, timer_clear, timer_en;
    logic           dec, inc;

    // The timer runs only in the two timed states and is zeroed everywhere else.
    assign timer_en     = (state == EXPLODE) || (state == INVULN);
    assign timer_clear  = !(state_nxt inside {EXPLODE, INVULN});
    assign timer_load   = (state_nxt != state) && (state_nxt inside {EXPLODE, INVULN});
    assign timer_reload = (state_nxt == INVULN) ? TW'(INVULN_FRAMES - 1) : TW'(FRAMES_PER_STEP - 1);

    frame_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .load       (timer_load),
        .enable     (timer_en),
        .tick       (vsync_pulse),
        .reload_val (timer_reload),
        .count_nxt  (timer_nxt),
        .tc         (timer_tc)
    );

    // Frames elapsed since INVULN entry, as seen after this edge; drives the blink.
    assign invuln_elapsed = TW'(INVULN_FRAMES - 1) - timer_nxt;

    // Life events: a collision only counts while ALIVE, bonus is ignored once over.
    assign dec = (state == ALIVE) && collision;
    assign inc = bonus && (state != OVER);

    // Next-state, lives arithmetic and registered-output decode.
    always_comb begin
        state_nxt         = state;
        lives_nxt         = lives;
        explode_frame_nxt = '0;
        ship_draw_nxt     = 1'b0;

        unique case (state)
            WAIT_START: if (start_done) state_nxt = ALIVE;
            ALIVE:      if (collision) state_nxt = EXPLODE;
            EXPLODE:    if (timer_tc && (explode_frame == EFW'(EXPLODE_STEPS - 1)))
                            state_nxt = (lives == '0) ? OVER : RESPAWN;
            RESPAWN:    state_nxt = INVULN;
            INVULN:     if (timer_tc) state_nxt = ALIVE;
            OVER:       state_nxt = OVER;
            default:    state_nxt = WAIT_START;
        endcase

        // Simultaneous bonus and death cancel; both ends saturate.
        unique case ({inc, dec})
            2'b01:   lives_nxt = (lives == '0) ? lives : lives - 1'b1;
            2'b10:   lives_nxt = (lives == LW'(MAX_NUM_LIVES)) ? lives : lives + 1'b1;
            default: lives_nxt = lives;
        endcase

        if (state_nxt == EXPLODE)
            explode_frame_nxt = (state == EXPLODE && timer_tc) ? explode_frame + 1'b1 : explode_frame;

        unique case (state_nxt)
            WAIT_START, ALIVE: ship_draw_nxt = 1'b1;
            INVULN:            ship_draw_nxt = ~invuln_elapsed[BLINK_LOG2];
            default:           ship_draw_nxt = 1'b0;
        endcase
    end

    // State, lives and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_START;
            lives          <= LW'(NUM_LIVES);
            explode_frame  <= '0;
            game_over      <= 1'b0;
            ship_draw      <= 1'b1;
            invulnerable   <= 1'b0;
            explode_active <= 1'b0;
            ship_respawn   <= 1'b0;
        end else begin
            state          <= state_nxt;
            lives          <= lives_nxt;
            explode_frame  <= explode_frame_nxt;
            game_over      <= (state_nxt == OVER);
            ship_draw      <= ship_draw_nxt;
            invulnerable   <= (state_nxt == INVULN);
            explode_active <= (state_nxt == EXPLODE);
            ship_respawn   <= (state_nxt == RESPAWN);
        end
    end

endmodule

// File: tb/tb_ship_life_ctrl.sv
// Scoreboard bench for ship_life_ctrl: stimulus pushes expected output
// snapshots, a negedge monitor pops and compares them.
module tb_ship_life_ctrl;
    import ship_life_pkg::*;

    logic               clk = 1'b0;
    logic               reset, vsync_pulse, start_done, collision, bonus;
    logic [LIVES_W-1:0] lives;
    logic               game_over, ship_draw, invulnerable, explode_active, ship_respawn;
    logic [1:0]         explode_frame;

    typedef struct {
        string              name;
        logic [LIVES_W-1:0] lives;
        logic               go, draw, inv, exa;
        logic [1:0]         exf;
        logic               resp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors      = 0;
    int   miscompares  = 0;
    int   respawn_seen = 0;

    ship_life_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .vsync_pulse    (vsync_pulse),
        .start_done     (start_done),
        .collision      (collision),
        .bonus          (bonus),
        .lives          (lives),
        .game_over      (game_over),
        .ship_draw      (ship_draw),
        .invulnerable   (invulnerable),
        .explode_active (explode_active),
        .explode_frame  (explode_frame),
        .ship_respawn   (ship_respawn)
    );

    always #5 clk = ~clk;

    // Monitor: count respawn pulses and check every queued snapshot.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ship_respawn === 1'b1) respawn_seen++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({lives, game_over, ship_draw, invulnerable, explode_active, explode_frame, ship_respawn} !==
                {e.lives, e.go, e.draw, e.inv, e.exa, e.exf, e.resp}) begin
                miscompares++;
                $display("FAIL %s: got lives=%0d go=%b draw=%b inv=%b exa=%b exf=%0d resp=%b, want lives=%0d go=%b draw=%b inv=%b exa=%b exf=%0d resp=%b",
                         e.name, lives, game_over, ship_draw, invulnerable, explode_active, explode_frame, ship_respawn,
                         e.lives, e.go, e.draw, e.inv, e.exa, e.exf, e.resp);
            end
        end
    end

    task automatic expect_out(input string name, input int l, input logic go, input logic draw,
                              input logic inv, input logic exa, input int exf, input logic resp);
        exp_t e;
        e.name = name; e.lives = LIVES_W'(l); e.go = go; e.draw = draw;
        e.inv = inv; e.exa = exa; e.exf = 2'(exf); e.resp = resp;
        exp_q.push_back(e);
    endtask

    // One clock: inputs applied for exactly one rising edge.
    task automatic step(input logic v, input logic c, input logic b);
        vsync_pulse = v; collision = c; bonus = b;
        @(posedge clk);
        #1;
        vsync_pulse = 1'b0; collision = 1'b0; bonus = 1'b0;
    endtask

    // A frame is four cycles ending with its vsync pulse.
    task automatic frames(input int n);
        repeat (n) begin
            step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1; start_done = 1'b0;
        vsync_pulse = 1'b0; collision = 1'b0; bonus = 1'b0;
        step(0, 0, 0); step(0, 0, 0);
        reset = 1'b0;
        expect_out("reset", 3, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0);
        expect_out("wait_start_ignores_collision", 3, 0, 1, 0, 0, 0, 0);

        // Start, then a long quiet stretch.
        start_done = 1'b1;
        step(0, 0, 0);
        frames(100);
        expect_out("alive_idle", 3, 0, 1, 0, 0, 0, 0);

        // First death with collision held for 50 cycles.
        step(0, 1, 0);
        expect_out("death1", 2, 0, 0, 0, 1, 0, 0);
        repeat (49) step(0, 1, 0);
        expect_out("collision_hold", 2, 0, 0, 0, 1, 0, 0);
        frames(5);  expect_out("explode_5", 2, 0, 0, 0, 1, 0, 0);
        frames(1);  expect_out("explode_6", 2, 0, 0, 0, 1, 1, 0);
        frames(6);  expect_out("explode_12", 2, 0, 0, 0, 1, 2, 0);
        frames(6);  expect_out("explode_18", 2, 0, 0, 0, 1, 3, 0);
        frames(5);  expect_out("explode_23", 2, 0, 0, 0, 1, 3, 0);
        frames(1);  expect_out("respawn1", 2, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        expect_out("invuln_enter", 2, 0, 1, 1, 0, 0, 0);
        frames(8);  expect_out("blink_off_8", 2, 0, 0, 1, 0, 0, 0);
        frames(8);  expect_out("blink_on_16", 2, 0, 1, 1, 0, 0, 0);

        // Collisions every frame while invulnerable are ignored.
        repeat (16) begin
            step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
        end
        expect_out("invuln_collide_32", 2, 0, 1, 1, 0, 0, 0);
        frames(57); expect_out("invuln_89", 2, 0, 0, 1, 0, 0, 0);
        frames(1);  expect_out("invuln_exit", 2, 0, 1, 0, 0, 0, 0);

        // Second death: collision coincides with vsync, that pulse is not counted.
        step(1, 1, 0);
        expect_out("death2_vsync", 1, 0, 0, 0, 1, 0, 0);
        frames(5);  expect_out("pulse_not_counted", 1, 0, 0, 0, 1, 0, 0);
        frames(1);  expect_out("death2_step1", 1, 0, 0, 0, 1, 1, 0);
        frames(18); expect_out("respawn2", 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        frames(90); expect_out("alive2", 1, 0, 1, 0, 0, 0, 0);

        // Bonus on the killing edge at lives=1: survive to RESPAWN.
        step(0, 1, 1);
        expect_out("bonus_collide", 1, 0, 0, 0, 1, 0, 0);
        frames(24); expect_out("respawn3", 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        frames(90); expect_out("alive3", 1, 0, 1, 0, 0, 0, 0);

        // Final death ends in OVER; everything afterwards is ignored.
        step(0, 1, 0);
        expect_out("death_last", 0, 0, 0, 0, 1, 0, 0);
        frames(23); expect_out("explode_last_23", 0, 0, 0, 0, 1, 3, 0);
        frames(1);  expect_out("game_over", 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1); step(0, 1, 0); frames(3);
        expect_out("over_sticky", 0, 1, 0, 0, 0, 0, 0);

        // Reset, bonus saturation, start_done drop, reset during EXPLODE.
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        expect_out("reset2", 3, 0, 1, 0, 0, 0, 0);
        repeat (7) step(0, 0, 1);
        expect_out("bonus_to_max", 10, 0, 1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 1);
        expect_out("bonus_saturated", 10, 0, 1, 0, 0, 0, 0);
        start_done = 1'b0;
        frames(2);
        expect_out("start_done_drop", 10, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0);
        frames(7);
        expect_out("explode_from_10", 9, 0, 0, 0, 1, 1, 0);
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        expect_out("reset_mid_explode", 3, 0, 1, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;

        vectors++;
        if (respawn_seen != 3) begin
            miscompares++;
            $display("FAIL respawn_count: got %0d pulses, want 3", respawn_seen);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d unchecked entries, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
